// File: rtl/serializer_tx_scheduler_if.sv
// Byte-side bundle between the word scheduler and its sources/serializer.
// master: source and retrain requester; slave: the scheduler itself.
`timescale 1ns/1ps
interface serializer_tx_scheduler_if;
  logic       train_req;
  logic [7:0] a_din;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_din;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] dout;
  logic [1:0] dout_src;
  logic       link_up;

  modport master (
    output train_req, a_din, a_valid, b_din, b_valid,
    input  a_ready, b_ready, dout, dout_src, link_up
  );

  modport slave (
    input  train_req, a_din, a_valid, b_din, b_valid,
    output a_ready, b_ready, dout, dout_src, link_up
  );
endinterface

// File: rtl/serializer_tx_scheduler.sv
// Word-level scheduler in front of the 8-bit serializer (one byte per clk40).
// Brings the link up with training words and a sync word, then in run mode
// inserts a periodic sync word and arbitrates source A (priority, burst
// limited) against bulk source B, filling empty slots with an idle byte.
// Optional macro SCHED_PRBS_IDLE_EN: idle slots carry PRBS-7 bytes instead of
// the fixed idle word.
`timescale 1ns/1ps
module serializer_tx_scheduler #(
  parameter int         TRAIN_WORDS = 64,
  parameter int         SYNC_PERIOD = 256,
  parameter int         MAX_A_BURST = 4,
  parameter logic [7:0] TRAIN_WORD  = 8'hF0,
  parameter logic [7:0] SYNC_WORD   = 8'h3C,
  parameter logic [7:0] IDLE_WORD   = 8'hC5
) (
  input logic                     clk40,
  input logic                     rstn,
  serializer_tx_scheduler_if.slave bus
);

  localparam int TCW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam int SCW = $clog2(SYNC_PERIOD);
  localparam int HCW = $clog2(MAX_A_BURST + 1);

  localparam logic [TCW-1:0] TRAIN_LAST    = TCW'(TRAIN_WORDS - 1);
  localparam logic [TCW-1:0] TRAIN_RESTART = (TRAIN_WORDS > 1) ? TCW'(1) : TCW'(0);
  localparam logic [SCW-1:0] SLOT_LAST     = SCW'(SYNC_PERIOD - 1);
  localparam logic [HCW-1:0] HOLD_MAX      = HCW'(MAX_A_BURST);

  localparam logic [1:0] ST_TRAIN = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [1:0] SRC_TRAIN = 2'd0;
  localparam logic [1:0] SRC_SYNC  = 2'd1;
  localparam logic [1:0] SRC_DATA  = 2'd2;
  localparam logic [1:0] SRC_IDLE  = 2'd3;

  logic [1:0]     state, state_nxt;
  logic [TCW-1:0] train_cnt, train_cnt_nxt;
  logic [SCW-1:0] slot_cnt, slot_cnt_nxt;
  logic [HCW-1:0] a_hold, a_hold_nxt;
  logic [7:0]     dout_nxt;
  logic [1:0]     src_nxt;
  logic [7:0]     idle_byte;
  logic           run_slot;
  logic           data_slot;
  logic           grant_a;
  logic           grant_b;

  // A retrain request steals the current slot, so only non-request RUN slots
  // past the sync position can carry source data.
  assign run_slot  = (state == ST_RUN) && !bus.train_req;
  assign data_slot = run_slot && (slot_cnt != '0);
  assign grant_a   = data_slot && bus.a_valid && ((a_hold < HOLD_MAX) || !bus.b_valid);
  assign grant_b   = data_slot && !grant_a && bus.b_valid;

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

`ifdef SCHED_PRBS_IDLE_EN
  logic [6:0] prbs_state;
  logic [6:0] prbs_walk;
  logic [7:0] prbs_byte;
  logic       prbs_fb;
  logic       idle_slot;

  assign idle_slot = data_slot && !grant_a && !grant_b;

  // Unroll eight x^7+x^6+1 steps; the earliest generated bit lands in bit 7
  always_comb begin
    prbs_walk = prbs_state;
    prbs_byte = '0;
    prbs_fb   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      prbs_fb      = prbs_walk[6] ^ prbs_walk[5];
      prbs_byte[i] = prbs_fb;
      prbs_walk    = {prbs_walk[5:0], prbs_fb};
    end
  end

  // Advance the generator only on slots that actually consume its byte
  always_ff @(posedge clk40) begin
    if (!rstn) begin
      prbs_state <= 7'h7F;
    end else if (idle_slot) begin
      prbs_state <= prbs_walk;
    end
  end

  assign idle_byte = prbs_byte;
`else
  assign idle_byte = IDLE_WORD;
`endif

  // Decide the content of this slot and the bring-up/run sequencing
  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    slot_cnt_nxt  = slot_cnt;
    a_hold_nxt    = a_hold;
    dout_nxt      = TRAIN_WORD;
    src_nxt       = SRC_TRAIN;
    case (state)
      ST_TRAIN: begin
        if (bus.train_req) begin
          train_cnt_nxt = '0;
        end else if (train_cnt == TRAIN_LAST) begin
          state_nxt     = ST_SYNC;
          train_cnt_nxt = '0;
        end else begin
          train_cnt_nxt = train_cnt + TCW'(1);
        end
      end
      ST_SYNC: begin
        if (bus.train_req) begin
          state_nxt     = ST_TRAIN;
          train_cnt_nxt = TRAIN_RESTART;
          slot_cnt_nxt  = '0;
          a_hold_nxt    = '0;
        end else begin
          dout_nxt     = SYNC_WORD;
          src_nxt      = SRC_SYNC;
          state_nxt    = ST_RUN;
          slot_cnt_nxt = SCW'(1);
        end
      end
      ST_RUN: begin
        if (bus.train_req) begin
          state_nxt     = ST_TRAIN;
          train_cnt_nxt = TRAIN_RESTART;
          slot_cnt_nxt  = '0;
          a_hold_nxt    = '0;
        end else begin
          slot_cnt_nxt = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SCW'(1);
          if (slot_cnt == '0) begin
            dout_nxt = SYNC_WORD;
            src_nxt  = SRC_SYNC;
          end else if (grant_a) begin
            dout_nxt   = bus.a_din;
            src_nxt    = SRC_DATA;
            a_hold_nxt = (a_hold < HOLD_MAX) ? a_hold + HCW'(1) : a_hold;
          end else if (grant_b) begin
            dout_nxt   = bus.b_din;
            src_nxt    = SRC_DATA;
            a_hold_nxt = '0;
          end else begin
            dout_nxt   = idle_byte;
            src_nxt    = SRC_IDLE;
            a_hold_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt     = ST_TRAIN;
        train_cnt_nxt = '0;
        slot_cnt_nxt  = '0;
        a_hold_nxt    = '0;
      end
    endcase
  end

  // Register state, counters and the slot result presented to the serializer
  always_ff @(posedge clk40) begin
    if (!rstn) begin
      state        <= ST_TRAIN;
      train_cnt    <= '0;
      slot_cnt     <= '0;
      a_hold       <= '0;
      bus.dout     <= 8'h00;
      bus.dout_src <= SRC_TRAIN;
      bus.link_up  <= 1'b0;
    end else begin
      state        <= state_nxt;
      train_cnt    <= train_cnt_nxt;
      slot_cnt     <= slot_cnt_nxt;
      a_hold       <= a_hold_nxt;
      bus.dout     <= dout_nxt;
      bus.dout_src <= src_nxt;
      bus.link_up  <= run_slot;
    end
  end

endmodule

// File: tb/tb_serializer_tx_scheduler.sv
// Self-checking bench for serializer_tx_scheduler: vector table, hand-written
// bring-up/sync/priority/retrain sequences and randomized traffic compared
// against a slot-level reference model. Honors SCHED_PRBS_IDLE_EN.
`timescale 1ns/1ps
module tb_serializer_tx_scheduler;

  localparam int         TRAIN_WORDS = 64;
  localparam int         SYNC_PERIOD = 256;
  localparam int         MAX_A_BURST = 4;
  localparam logic [7:0] TRAIN_WORD  = 8'hF0;
  localparam logic [7:0] SYNC_WORD   = 8'h3C;
  localparam logic [7:0] IDLE_WORD   = 8'hC5;

  logic clk40 = 1'b0;
  logic rstn  = 1'b0;

  always #5 clk40 = ~clk40;

  serializer_tx_scheduler_if bus();

  serializer_tx_scheduler #(
    .TRAIN_WORDS(TRAIN_WORDS), .SYNC_PERIOD(SYNC_PERIOD), .MAX_A_BURST(MAX_A_BURST),
    .TRAIN_WORD(TRAIN_WORD), .SYNC_WORD(SYNC_WORD), .IDLE_WORD(IDLE_WORD)
  ) dut (
    .clk40(clk40),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // reference model: words of training left, run flag, position in sync period
  int m_train_left;
  bit m_run;
  int m_pos;
  int m_streak;
`ifdef SCHED_PRBS_IDLE_EN
  int pq[$];
`endif

  logic [7:0] a_seq, b_seq;
  logic [7:0] last_d;
  logic [1:0] last_s;
  logic       last_lk, last_ar, last_br;

  typedef struct packed {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ar;
    logic       br;
    logic [7:0] d;
    logic [1:0] s;
    logic       chk_d;
  } vec_t;

  vec_t tbl[13];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_train_left = TRAIN_WORDS;
    m_run        = 1'b0;
    m_pos        = 0;
    m_streak     = 0;
`ifdef SCHED_PRBS_IDLE_EN
    pq = {1, 1, 1, 1, 1, 1, 1};
`endif
  endfunction

  function automatic logic [7:0] model_idle();
    logic [7:0] r;
    r = IDLE_WORD;
`ifdef SCHED_PRBS_IDLE_EN
    for (int i = 0; i < 8; i++) begin
      int nb;
      nb = pq[0] ^ pq[1];
      pq.push_back(nb);
      void'(pq.pop_front());
      r[7-i] = nb[0];
    end
`endif
    return r;
  endfunction

  function automatic void model_step(input logic tr, input logic av, input logic [7:0] ad,
                                     input logic bv, input logic [7:0] bd,
                                     output logic ga, output logic gb, output logic [7:0] d,
                                     output logic [1:0] s, output logic lk);
    ga = 1'b0; gb = 1'b0; d = TRAIN_WORD; s = 2'd0; lk = 1'b0;
    if (!m_run) begin
      if (m_train_left > 0) begin
        m_train_left = tr ? TRAIN_WORDS : m_train_left - 1;
      end else if (tr) begin
        m_train_left = TRAIN_WORDS - 1;
      end else begin
        d = SYNC_WORD; s = 2'd1; m_run = 1'b1; m_pos = 1;
      end
    end else if (tr) begin
      m_run = 1'b0; m_train_left = TRAIN_WORDS - 1; m_streak = 0; m_pos = 0;
    end else begin
      lk = 1'b1;
      if (m_pos == 0) begin
        d = SYNC_WORD; s = 2'd1;
      end else if (av && (m_streak < MAX_A_BURST || !bv)) begin
        ga = 1'b1; d = ad; s = 2'd2;
        if (m_streak < MAX_A_BURST) m_streak++;
      end else if (bv) begin
        gb = 1'b1; d = bd; s = 2'd2; m_streak = 0;
      end else begin
        d = model_idle(); s = 2'd3; m_streak = 0;
      end
      m_pos = (m_pos + 1) % SYNC_PERIOD;
    end
  endfunction

  // one slot: drive at negedge, check readys, then check the registered result
  task automatic apply_stimulus(input logic tr, input logic av, input logic [7:0] ad,
                                input logic bv, input logic [7:0] bd,
                                output logic ar, output logic br, output logic [7:0] d,
                                output logic [1:0] s, output logic lk);
    logic ega, egb, elk;
    logic [7:0] ed;
    logic [1:0] es;
    bus.train_req = tr; bus.a_valid = av; bus.a_din = ad; bus.b_valid = bv; bus.b_din = bd;
    #1;
    model_step(tr, av, ad, bv, bd, ega, egb, ed, es, elk);
    ar = bus.a_ready;
    br = bus.b_ready;
    check_output("a_ready", {31'd0, ar}, {31'd0, ega});
    check_output("b_ready", {31'd0, br}, {31'd0, egb});
    @(posedge clk40);
    @(negedge clk40);
    d  = bus.dout;
    s  = bus.dout_src;
    lk = bus.link_up;
    check_output("dout", {24'd0, d}, {24'd0, ed});
    check_output("dout_src", {30'd0, s}, {30'd0, es});
    check_output("link_up", {31'd0, lk}, {31'd0, elk});
  endtask

  task automatic run_cycle(input logic tr, input logic av, input logic bv);
    logic ar, br, lk;
    logic [7:0] d;
    logic [1:0] s;
    apply_stimulus(tr, av, a_seq, bv, b_seq, ar, br, d, s, lk);
    if (ar) a_seq++;
    if (br) b_seq++;
    last_d = d; last_s = s; last_lk = lk; last_ar = ar; last_br = br;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_dout"}, {24'd0, bus.dout}, 32'h00);
    check_output({tag, "_src"}, {30'd0, bus.dout_src}, 32'd0);
    check_output({tag, "_link"}, {31'd0, bus.link_up}, 32'd0);
    check_output({tag, "_a_ready"}, {31'd0, bus.a_ready}, 32'd0);
    check_output({tag, "_b_ready"}, {31'd0, bus.b_ready}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] bu_d[70];
    logic [1:0] bu_s[70];
    logic       bu_l[70];
    logic ar, br, lk;
    logic [7:0] d, b_out_exp;
    logic [1:0] s;
    int first_non_train, last_sync, a_run, f0_count;
    bit seen_b, sync_seen;

    tbl[0]  = '{1'b1, 8'h11, 1'b1, 8'hB0, 1'b1, 1'b0, 8'h11, 2'd2, 1'b1};
    tbl[1]  = '{1'b1, 8'h12, 1'b1, 8'hB0, 1'b1, 1'b0, 8'h12, 2'd2, 1'b1};
    tbl[2]  = '{1'b1, 8'h13, 1'b1, 8'hB0, 1'b1, 1'b0, 8'h13, 2'd2, 1'b1};
    tbl[3]  = '{1'b1, 8'h14, 1'b1, 8'hB0, 1'b1, 1'b0, 8'h14, 2'd2, 1'b1};
    tbl[4]  = '{1'b1, 8'h15, 1'b1, 8'hB0, 1'b0, 1'b1, 8'hB0, 2'd2, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'hB1, 1'b0, 1'b1, 8'hB1, 2'd2, 1'b1};
    tbl[6]  = '{1'b1, 8'h16, 1'b0, 8'h00, 1'b1, 1'b0, 8'h16, 2'd2, 1'b1};
    tbl[7]  = '{1'b1, 8'h17, 1'b0, 8'h00, 1'b1, 1'b0, 8'h17, 2'd2, 1'b1};
    tbl[8]  = '{1'b1, 8'h18, 1'b0, 8'h00, 1'b1, 1'b0, 8'h18, 2'd2, 1'b1};
    tbl[9]  = '{1'b1, 8'h19, 1'b0, 8'h00, 1'b1, 1'b0, 8'h19, 2'd2, 1'b1};
    tbl[10] = '{1'b1, 8'h1A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h1A, 2'd2, 1'b1};
    tbl[11] = '{1'b1, 8'h1B, 1'b1, 8'hB2, 1'b0, 1'b1, 8'hB2, 2'd2, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, IDLE_WORD, 2'd3, 1'b0};

    a_seq = 8'h00; b_seq = 8'h00;

    // reset held with valids asserted: nothing may be granted
    bus.train_req = 1'b0; bus.a_valid = 1'b1; bus.a_din = 8'h55;
    bus.b_valid = 1'b1; bus.b_din = 8'hAA;
    rstn = 1'b0;
    repeat (5) @(negedge clk40);
    check_reset_outputs("reset");
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    rstn = 1'b1;
    model_reset();

    // bring-up with no traffic
    for (int i = 0; i < 70; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, ar, br, d, s, lk);
      bu_d[i] = d; bu_s[i] = s; bu_l[i] = lk;
    end
    first_non_train = 70;
    for (int i = 69; i >= 0; i--)
      if (!(bu_s[i] == 2'd0 && bu_d[i] == TRAIN_WORD)) first_non_train = i;
    check_output("bringup_train_count", first_non_train, TRAIN_WORDS);
    check_output("bringup_sync_word", {24'd0, bu_d[64]}, {24'd0, SYNC_WORD});
    check_output("bringup_sync_src", {30'd0, bu_s[64]}, 32'd1);
    check_output("bringup_link_at_sync", {31'd0, bu_l[64]}, 32'd0);
    check_output("bringup_link_after_sync", {31'd0, bu_l[65]}, 32'd1);
    check_output("bringup_idle_src", {30'd0, bu_s[65]}, 32'd3);

    // table-driven run-mode vectors
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(1'b0, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, ar, br, d, s, lk);
      check_output($sformatf("tbl%0d_a_ready", i), {31'd0, ar}, {31'd0, tbl[i].ar});
      check_output($sformatf("tbl%0d_b_ready", i), {31'd0, br}, {31'd0, tbl[i].br});
      check_output($sformatf("tbl%0d_src", i), {30'd0, s}, {30'd0, tbl[i].s});
      if (tbl[i].chk_d)
        check_output($sformatf("tbl%0d_dout", i), {24'd0, d}, {24'd0, tbl[i].d});
    end

    // periodic sync with B streaming
    b_out_exp = b_seq;
    last_sync = -1;
    for (int i = 0; i < 600; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (last_s == 2'd1) begin
        check_output("sync_b_ready", {31'd0, last_br}, 32'd0);
        if (last_sync >= 0) check_output("sync_spacing", i - last_sync, SYNC_PERIOD);
        last_sync = i;
      end else if (last_s == 2'd2) begin
        check_output("sync_b_stream", {24'd0, last_d}, {24'd0, b_out_exp});
        b_out_exp++;
      end
    end

    // priority and starvation limit with both sources always valid
    seen_b = 1'b0; a_run = 0;
    for (int i = 0; i < 600; i++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      if (last_ar) a_run++;
      if (last_br) begin
        if (seen_b) check_output("prio_a_burst", a_run, MAX_A_BURST);
        seen_b = 1'b1; a_run = 0;
      end
    end

    // random A with B absent
    for (int i = 0; i < 300; i++) run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // retrain during a B burst
    for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b0, 1'b1);
    b_out_exp = b_seq;
    run_cycle(1'b1, 1'b0, 1'b1);
    check_output("retrain_b_ready", {31'd0, last_br}, 32'd0);
    check_output("retrain_link", {31'd0, last_lk}, 32'd0);
    check_output("retrain_src", {30'd0, last_s}, 32'd0);
    f0_count = 1; sync_seen = 1'b0;
    for (int i = 0; i < 200 && !sync_seen; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (last_s == 2'd0 && last_d == TRAIN_WORD) f0_count++;
      else if (last_s == 2'd1) sync_seen = 1'b1;
    end
    check_output("retrain_sync_seen", {31'd0, sync_seen}, 32'd1);
    check_output("retrain_train_words", f0_count, TRAIN_WORDS);
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (last_s == 2'd2) begin
        check_output("retrain_b_stream", {24'd0, last_d}, {24'd0, b_out_exp});
        b_out_exp++;
      end
    end

    // reset in the middle of run mode
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.train_req = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk40);
    check_reset_outputs("midreset");
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    rstn = 1'b1;
    model_reset();

    // idle-only run across a sync slot
    for (int i = 0; i < 400; i++) run_cycle(1'b0, 1'b0, 1'b0);

    // random traffic with occasional retrain
    for (int i = 0; i < 3000; i++)
      run_cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serializer_tx_scheduler.md
Name: serializer_tx_scheduler

Overview:
- Word-level controller in front of the 8-bit MSB-first serializer. Runs at 40 MHz and produces one byte per clk40 cycle, which is the serializer's parallel input.
- Sequences link bring-up: a training pattern, then a sync word, then run mode.
- In run mode it inserts a periodic sync word and arbitrates two byte sources: A is the high-priority command/trigger source, B is the bulk data source.
- Fills empty slots with an idle word.

Parameters:
- TRAIN_WORDS, 64, number of training words sent per training sequence (>=1).
- SYNC_PERIOD, 256, run-mode slots per sync word, counting the sync slot itself (>=2).
- MAX_A_BURST, 4, maximum consecutive A grants while B is waiting (>=1).
- TRAIN_WORD, 8'hF0, training byte.
- SYNC_WORD, 8'h3C, alignment byte.
- IDLE_WORD, 8'hC5, filler byte.

Ports:
- clk40  in  1  word clock.
- rstn  in  1  synchronous active-low reset.
- train_req  in  1  request link retraining.
- a_din  in  8  source A byte.
- a_valid  in  1  source A has a byte.
- a_ready  out  1  source A byte consumed this cycle.
- b_din  in  8  source B byte.
- b_valid  in  1  source B has a byte.
- b_ready  out  1  source B byte consumed this cycle.
- dout  out  8  byte to serializer din.
- dout_src  out  2  source of dout: 0=train, 1=sync, 2=A/B data, 3=idle.
- link_up  out  1  high while in RUN.

Behaviour:
- Reset: clk40 is the only clock. rstn is sampled on posedge clk40. While rstn=0:
  - dout=8'h00, dout_src=0, link_up=0, a_ready=b_ready=0.
  - state=TRAIN, all counters cleared.
- dout, dout_src and link_up are registered. A slot decided in cycle n appears on dout in cycle n+1 (latency 1).
- a_ready and b_ready are combinational and equal the grant in the current cycle.
  - A byte transfers when valid&ready in the same cycle.
  - Ready may depend on valid; a source must not wait for ready before asserting valid.
- States:
  - TRAIN: each slot emits TRAIN_WORD and increments train_cnt. When train_cnt==TRAIN_WORDS-1 and train_req=0, go to SYNC. While train_req=1, train_cnt is held at 0.
  - SYNC: one slot emits SYNC_WORD, then go to RUN with slot_cnt=1.
  - RUN: slot_cnt counts 0..SYNC_PERIOD-1 and wraps. Slot priority each cycle:
    1. slot_cnt==0: emit SYNC_WORD, no grant; a_hold unchanged.
    2. a_valid and (a_hold<MAX_A_BURST or b_valid=0): grant A, emit a_din, a_hold++ (saturates at MAX_A_BURST).
    3. b_valid: grant B, emit b_din, a_hold=0.
    4. Otherwise emit IDLE_WORD, a_hold=0.
- train_req=1 in RUN or SYNC:
  - The current slot is a training slot: no grants, emit TRAIN_WORD.
  - Next state is TRAIN with train_cnt=1, slot_cnt=0, a_hold=0.
  - No accepted byte is lost, because grant and consume happen in the same cycle.
- Counter widths: $clog2 of their range. slot_cnt never exceeds SYNC_PERIOD-1; train_cnt never exceeds TRAIN_WORDS-1.
- a_ready and b_ready are never both 1 in the same cycle, and both are 0 outside RUN.

Optional Feature:
- Macro SCHED_PRBS_IDLE_EN.
- Defined:
  - Idle slots emit the next byte of a PRBS-7 generator (x^7+x^6+1, seed 7'h7F on reset). The byte is 8 consecutive PRBS bits, first bit in dout[7].
  - The generator advances only on idle slots.
  - dout_src remains 3.
- Undefined: idle slots emit IDLE_WORD, and no PRBS logic is synthesized.

Test Plan:
- Reset: hold rstn=0 for 5 cycles, then release with no valids.
  - Expect exactly 64 dout=8'hF0 (src 0), then one 8'h3C (src 1), then 8'hC5 (src 3).
  - link_up rises the cycle after the sync word is emitted.
- Periodic sync: in RUN with b_valid held 1 and a stream 0x00,0x01,... continuously.
  - Expect 8'h3C every 256th output word, with b_ready=0 on those cycles.
  - The B byte sequence is unbroken across the sync word.
- Priority and starvation: a_valid=b_valid=1 continuously.
  - Expect the grant pattern A,A,A,A,B repeating, interrupted only by sync slots.
  - a_hold is preserved across a sync slot.
- Backpressure/idle: toggle a_valid at random, b_valid=0.
  - Every cycle with a_valid=1 and a non-sync slot is granted and appears on dout one cycle later; all other slots are 8'hC5.
- Retrain mid-run: pulse train_req for 1 cycle during a B burst.
  - B is not granted that cycle; link_up falls.
  - 64 training words follow (counting the request slot), then sync, then the B stream resumes with no byte lost or duplicated.
- SCHED_PRBS_IDLE_EN defined, no valids after bring-up: the idle bytes match a reference PRBS-7 model starting from seed 7'h7F, and the generator does not advance on sync slots.
